window_3x3: RTL

WINDOW_3X3 -- requirements
Module: window_3x3

---
 rtl/window_3x3.sv | 117 +++++++++++
 1 files changed

// File: rtl/window_3x3.sv
// rtl/window_3x3.sv - 3x3 sliding window generator over a raster-order pixel stream
//
// Purpose: builds every fully-interior 3x3 neighbourhood of an IMG_WIDTH x IMG_HEIGHT
// frame from two line buffers and three column shift registers. Output is held in a
// single register with valid/ready handshake; in_ready = !out_valid || out_ready.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_pixel carries a valid pixel
//   in_pixel   in   8-bit grey pixel, raster order
//   in_ready   out  pixel accepted this cycle when in_valid is also high
//   out_valid  out  win holds a valid window
//   out_ready  in   downstream takes win this cycle
//   win        out  win[r][c], r=0 oldest line, c=0 leftmost column
//   out_last   out  win is the final window of the frame
module window_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_pixel,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0][2:0][7:0]  win,
  output logic                  out_last
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [2:0][2:0][7:0]   win_q, win_d;

  // line0 holds the line two above the current one, line1 the line directly above
  logic [7:0] line0_mem [IMG_WIDTH];
  logic [7:0] line1_mem [IMG_WIDTH];

  logic       in_fire;
  logic       win_ok;
  logic [7:0] up2_px;
  logic [7:0] up1_px;

  assign in_ready  = !out_valid_q || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign up2_px    = line0_mem[col_q];
  assign up1_px    = line1_mem[col_q];
  // Only positions with two full lines and two full columns behind them form a window
  assign win_ok    = (col_q >= CW'(2)) && (row_q >= RW'(2));

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign win       = win_q;

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (in_fire) begin
      // The shift registers double as the output register: they only move on an input
      // transfer, which cannot happen while a window is stalled downstream.
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = up2_px;
      win_d[1][2] = up1_px;
      win_d[2][2] = in_pixel;
      out_valid_d = win_ok;
      out_last_d  = win_ok && (col_q == COL_MAX) && (row_q == ROW_MAX);
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      win_q       <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      win_q       <= win_d;
    end
  end

  // Line buffers carry no reset; stale contents never pass the row gating
  always_ff @(posedge clk) begin
    if (in_fire) begin
      line0_mem[col_q] <= line1_mem[col_q];
      line1_mem[col_q] <= in_pixel;
    end
  end

endmodule
